// File: rtl/time_keeper_if.sv
// Setter-to-time_keeper bus: load strobe and HH/MM/SS values in,
// display-ready time, blank mask and second pulse out.
// The chime signal exists only when CHIME_EN is defined.
interface time_keeper_if;
  logic       load;
  logic [6:0] inHH;
  logic [6:0] inMM;
  logic [6:0] inSS;
  logic       showAP;
  logic [5:0] in_flick;
  logic [6:0] outHH;
  logic [6:0] outMM;
  logic [6:0] outSS;
  logic       out_pm;
  logic [5:0] out_blank;
  logic       sec_tick;
`ifdef CHIME_EN
  logic       chime;
`endif

  // Setter side: drives the load bus, observes the display outputs.
  modport master (
    output load, inHH, inMM, inSS, showAP, in_flick,
    input  outHH, outMM, outSS, out_pm, out_blank, sec_tick
`ifdef CHIME_EN
    , input chime
`endif
  );

  // Time keeper side.
  modport slave (
    input  load, inHH, inMM, inSS, showAP, in_flick,
    output outHH, outMM, outSS, out_pm, out_blank, sec_tick
`ifdef CHIME_EN
    , output chime
`endif
  );
endinterface

// File: rtl/time_keeper.sv
// Free-running time-of-day counter. Captures HH/MM/SS on a load strobe,
// then advances once per second from a prescaled clk_2MHz. Drives 24/12-hour
// display hours, a PM flag and a blink-gated digit blank mask.
// Optional feature: define CHIME_EN to add an hourly chime pulse.
module time_keeper #(
  parameter int TICKS_PER_SEC = 2000000
) (
  input  logic         clk_2MHz,
  input  logic         reset,
  time_keeper_if.slave tk
);

  localparam int PRE_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(TICKS_PER_SEC / 2 - 1);

  logic [PRE_W-1:0] pre;
  logic [6:0]       hh, mm, ss;
  logic             phase;
  logic             sec_tick_q;
  logic [6:0]       disp_hh;
`ifdef CHIME_EN
  logic             chime_q;
`endif

  // Prescaler, time counters and blink phase; a load overrides counting.
  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk_2MHz or posedge reset) begin
    if (reset) begin
      pre        <= '0;
      hh         <= '0;
      mm         <= '0;
      ss         <= '0;
      phase      <= 1'b0;
      sec_tick_q <= 1'b0;
`ifdef CHIME_EN
      chime_q    <= 1'b0;
`endif
    end else if (tk.load) begin
      // Out-of-range fields load as zero; the pending second is dropped.
      hh         <= (tk.inHH > 7'd23) ? 7'd0 : tk.inHH;
      mm         <= (tk.inMM > 7'd59) ? 7'd0 : tk.inMM;
      ss         <= (tk.inSS > 7'd59) ? 7'd0 : tk.inSS;
      pre        <= '0;
      phase      <= 1'b0;
      sec_tick_q <= 1'b0;
`ifdef CHIME_EN
      chime_q    <= 1'b0;
`endif
    end else begin
      if (pre == PRE_HALF || pre == PRE_LAST)
        phase <= ~phase;
      if (pre == PRE_LAST) begin
        pre        <= '0;
        sec_tick_q <= 1'b1;
        if (ss == 7'd59) begin
          ss <= 7'd0;
          if (mm == 7'd59) begin
            mm <= 7'd0;
            hh <= (hh == 7'd23) ? 7'd0 : hh + 7'd1;
          end else begin
            mm <= mm + 7'd1;
          end
        end else begin
          ss <= ss + 7'd1;
        end
`ifdef CHIME_EN
        chime_q <= (ss == 7'd59) && (mm == 7'd59);
`endif
      end else begin
        pre        <= pre + 1'b1;
        sec_tick_q <= 1'b0;
`ifdef CHIME_EN
        chime_q    <= 1'b0;
`endif
      end
    end
  end

  // Display hour: 12-hour mode maps 0 to 12 and 13..23 to 1..11.
  // NOTE: disp_hh gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    disp_hh = hh;
    if (tk.showAP) begin
      if (hh == 7'd0)
        disp_hh = 7'd12;
      else if (hh > 7'd12)
        disp_hh = hh - 7'd12;
    end
  end

  assign tk.outHH     = disp_hh;
  assign tk.outMM     = mm;
  assign tk.outSS     = ss;
  assign tk.out_pm    = (hh >= 7'd12);
  assign tk.out_blank = tk.in_flick & {6{phase}};
  assign tk.sec_tick  = sec_tick_q;
`ifdef CHIME_EN
  assign tk.chime     = chime_q;
`endif

endmodule

// File: doc/time_keeper.md
# time_keeper

Free-running time-of-day counter that consumes the time setter's output. On a one-cycle `load` pulse it captures the HH/MM/SS values. Between loads it advances once per second from a prescaled `clk_2MHz`. It drives display-ready hours, with optional 12-hour conversion, plus a blink-gated digit blank mask derived from the setter's flick vector.

## Interface
- `TICKS_PER_SEC`, default 2000000: clock cycles per second; minimum 2, must be even.
- `clk_2MHz`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `load`  in  1  one-cycle capture strobe from the setter.
- `inHH`  in  7  hours to load, 0–23.
- `inMM`  in  7  minutes to load, 0–59.
- `inSS`  in  7  seconds to load, 0–59.
- `showAP`  in  1  1 selects 12-hour display, 0 selects 24-hour display.
- `in_flick`  in  6  digit-pair select from the setter: [5:4] HH, [3:2] MM, [1:0] SS.
- `outHH`  out  7  display hours; 1–12 when `showAP`=1, 0–23 otherwise.
- `outMM`  out  7  minutes, 0–59.
- `outSS`  out  7  seconds, 0–59.
- `out_pm`  out  1  1 when internal hour ≥ 12, independent of `showAP`.
- `out_blank`  out  6  digits to blank this cycle.
- `sec_tick`  out  1  one-cycle pulse on each counted second.
- `chime`  out  1  hourly pulse; present only with `CHIME_EN`.

## Operation
- State:
  - prescaler `pre`, 0..TICKS_PER_SEC-1;
  - internal `hh` (0–23), `mm`, `ss`;
  - blink `phase`.
- Prescaler:
  - increments every cycle;
  - at `pre`=TICKS_PER_SEC-1 it wraps to 0 and a second is counted.
- Second count:
  - `ss` 59→0 carries to `mm`;
  - `mm` 59→0 carries to `hh`;
  - `hh` 23→0 wraps with no further carry.
- Load:
  - when `load`=1, `hh`/`mm`/`ss` take `inHH`/`inMM`/`inSS`;
  - `pre` clears to 0 and `phase` clears to 0.
  - Out-of-range input loads 0 for that field: `inHH`>23 → 0, `inMM`>59 → 0, `inSS`>59 → 0.
- Load vs. count in the same cycle: load wins. The second is dropped and `sec_tick` stays 0.
- Blink `phase` toggles when `pre` = TICKS_PER_SEC/2-1 and again when `pre` = TICKS_PER_SEC-1.
- `out_blank` = `in_flick` & {6{`phase`}}, combinational from the registered `phase`.
- Display hour, combinational from `hh` and `showAP`:
  - with `showAP`=1: `hh`=0 → 12; 1–12 → `hh`; 13–23 → `hh`-12;
  - with `showAP`=0: `outHH` = `hh`.
- `outMM` = `mm`, `outSS` = `ss`, `out_pm` = (`hh` ≥ 12).
- All arithmetic is 7-bit unsigned; the prescaler is sized to hold TICKS_PER_SEC-1.

## Timing
- Reset values, asynchronous and immediate:
  - internal `hh`/`mm`/`ss`/`pre` = 0 and `phase` = 0;
  - `outMM`/`outSS` = 0, `out_pm` = 0, `out_blank` = 0, `sec_tick` = 0, `chime` = 0;
  - `outHH` = 0 when `showAP`=0, 12 when `showAP`=1.
- First `sec_tick` comes TICKS_PER_SEC edges after `reset` deasserts. It is registered: high for exactly the cycle in which `ss` shows the new value.
- Load latency is 1 cycle: values are visible on the cycle after the edge that samples `load`=1. The next second is counted TICKS_PER_SEC edges after that edge.
- Reset asserted mid-count or coincident with `load` wins over everything.
- Holding `load` high for several cycles reloads every cycle and blocks counting.
- `showAP` and `in_flick` changes take effect combinationally with no state change.

## Configuration
- `CHIME_EN` defined:
  - the `chime` port exists;
  - it is a registered one-cycle pulse, coincident with `sec_tick`, when counting produces `mm`=0 and `ss`=0;
  - it never fires on load, including a load of xx:00:00.
- `CHIME_EN` undefined: no `chime` port and no chime logic.

## Test plan
All scenarios run with TICKS_PER_SEC=4.
- Reset, then 4 cycles → `sec_tick` pulses once and `outSS`=1. After 240 cycles → `outMM`=1, `outSS`=0.
- Load 23:59:59, then 4 cycles → `outHH`/`outMM`/`outSS` = 0/0/0, `out_pm`=0. With `CHIME_EN`, `chime`=1 for that single cycle.
- Load 0:05:00 with `showAP`=1 → `outHH`=12, `out_pm`=0. Load 13:00:00 → `outHH`=1, `out_pm`=1. Set `showAP`=0 → `outHH`=13 in the same cycle.
- Assert `load` (10:20:30) in the cycle where `pre`=3 → 10:20:30 shown with no increment and `sec_tick`=0. Next `sec_tick` comes 4 edges later with `outSS`=31.
- `in_flick`=110000 with no load → `out_blank` = 000000, 110000, 000000 in alternating 2-cycle windows. A load returns it to 000000.
- Load `inHH`=30, `inMM`=70, `inSS`=5 → 0:00:05. Assert `reset` mid-count → all outputs at reset values immediately, without waiting for a clock edge.
